// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the common data bus.
// Define CDB_ARB_BYPASS_EN for combinational (0-cycle) broadcast outputs.
module cdb_arbiter #(
  parameter int N_REQ         = 4,
  parameter int DATA_WIDTH    = 4,
  parameter int CDB_TAG_WIDTH = 4,
  parameter int TAG_BASE      = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]            accepted_o,
  input  logic                        cdb_enable_i,
  output logic                        cdb_valid_o,
  output logic [CDB_TAG_WIDTH-1:0]    cdb_tag_o,
  output logic [DATA_WIDTH-1:0]       cdb_data_o
);

  localparam int PW  = $clog2(N_REQ);
  localparam int PW1 = PW + 1;
  localparam logic [PW:0] NQ = PW1'(N_REQ);

  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_nreq
    $error("cdb_arbiter: N_REQ must be in 2..16");
  end
  if (DATA_WIDTH < 1) begin : g_bad_dw
    $error("cdb_arbiter: DATA_WIDTH must be >= 1");
  end
  if (TAG_BASE < 1) begin : g_bad_base
    $error("cdb_arbiter: TAG_BASE must be >= 1");
  end
  if (CDB_TAG_WIDTH < 1 || CDB_TAG_WIDTH > 31 ||
      (TAG_BASE + N_REQ - 1) >= (1 << CDB_TAG_WIDTH)) begin : g_bad_tag
    $error("cdb_arbiter: CDB_TAG_WIDTH cannot hold TAG_BASE+N_REQ-1");
  end

  logic [PW-1:0]            r_rr_ptr;
  logic [PW:0]              w_sum;
  logic [PW-1:0]            w_idx;
  logic [PW-1:0]            w_gidx;
  logic [PW-1:0]            w_next;
  logic                     w_found;
  logic                     w_grant;
  logic [CDB_TAG_WIDTH-1:0] w_tag;
  logic [DATA_WIDTH-1:0]    w_data;

  // Scan from rr_ptr upward, wrapping modulo N_REQ; first requester wins
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + PW1'(k);
      if (w_sum >= NQ) begin
        w_sum = w_sum - NQ;
      end
      w_idx = w_sum[PW-1:0];
      if (!w_found && req_i[w_idx]) begin
        w_found = 1'b1;
        w_gidx  = w_idx;
      end
    end
  end

  // Grant qualification, one-hot accept, winner tag/data, next pointer
  always_comb begin
    w_grant    = rst_n & cdb_enable_i & w_found;
    accepted_o = w_grant ? (N_REQ'(1) << w_gidx) : '0;
    w_next     = (w_gidx == PW'(N_REQ - 1)) ? '0 : w_gidx + 1'b1;
    w_tag      = CDB_TAG_WIDTH'(TAG_BASE) + CDB_TAG_WIDTH'(w_gidx);
    w_data     = req_data_i[int'(w_gidx)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin pointer moves past the winner on every grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_rr_ptr <= w_next;
    end
  end

`ifdef CDB_ARB_BYPASS_EN
  // Broadcast the current winner directly, zero when idle
  always_comb begin
    cdb_valid_o = w_grant;
    cdb_tag_o   = w_grant ? w_tag  : '0;
    cdb_data_o  = w_grant ? w_data : '0;
  end
`else
  logic                     r_valid;
  logic [CDB_TAG_WIDTH-1:0] r_tag;
  logic [DATA_WIDTH-1:0]    r_data;

  // Register the winner for broadcast; tag/data hold when idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (w_grant) begin
      r_valid <= 1'b1;
      r_tag   <= w_tag;
      r_data  <= w_data;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign cdb_valid_o = r_valid;
  assign cdb_tag_o   = r_tag;
  assign cdb_data_o  = r_data;
`endif

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the single common data bus (CDB) between N_REQ result producers, such as ALU reservation stations and load units.
- Each cycle it grants at most one requester, using round-robin order.
- It returns a same-cycle `accepted` pulse to the winner and broadcasts the winner's data next cycle on the registered CDB outputs, tagged with the winner's identity.
- It sits between the producers' CDB-producer ports and every CDB listener (the reservation station operand listeners and the register file).

Parameters:
- N_REQ, 4, number of requesters; 2..16.
- DATA_WIDTH, 4, CDB data width.
- CDB_TAG_WIDTH, 4, CDB tag width; must hold TAG_BASE+N_REQ-1.
- TAG_BASE, 1, tag of requester 0; requester i uses tag TAG_BASE+i. Tag 0 stays free to mean "no producer".

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- req_i  input  N_REQ  per-requester CDB write request (level, held until accepted)
- req_data_i  input  N_REQ*DATA_WIDTH  packed result data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- accepted_o  output  N_REQ  one-hot grant, combinational, same cycle as request
- cdb_enable_i  input  1  global grant enable; when 0, no grants are issued
- cdb_valid_o  output  1  CDB broadcast valid (registered)
- cdb_tag_o  output  CDB_TAG_WIDTH  tag of broadcast producer (registered)
- cdb_data_o  output  DATA_WIDTH  broadcast data (registered)

Behaviour:
- Reset state: when rst_n=0 at a clk edge:
  - rr_ptr<=0, cdb_valid_o<=0, cdb_tag_o<=0, cdb_data_o<=0.
  - accepted_o is forced to all-zero combinationally while rst_n=0, so no producer retires during reset.
- rr_ptr: a ceil(log2(N_REQ))-bit register holding the highest-priority index.
- Grant search:
  - Scan indices rr_ptr, rr_ptr+1, ..., wrapping modulo N_REQ (not modulo 2^width; non-power-of-two N_REQ must wrap correctly).
  - The first index with req_i set wins.
  - accepted_o is one-hot on the winner and is asserted only if rst_n=1 and cdb_enable_i=1.
- Grant edge: at the clk edge of a grant to index g:
  - cdb_valid_o<=1, cdb_tag_o<=TAG_BASE+g, cdb_data_o<=req_data_i[g].
  - rr_ptr<=(g+1) mod N_REQ; g=N_REQ-1 wraps to 0.
- No-grant edge: when there are no requests or cdb_enable_i=0:
  - cdb_valid_o<=0; cdb_tag_o and cdb_data_o hold their previous values.
  - rr_ptr holds.
- Latency:
  - Request to accepted: 0 cycles.
  - Request to CDB broadcast: 1 cycle.
  - Throughput: one broadcast per cycle, back-to-back, with no bubble.
- Fairness: any continuously asserted request is granted within N_REQ grant cycles.
- Producer handshake: a producer deasserts its request the cycle after `accepted` and may raise a new request in that same cycle. The arbiter treats it as a fresh request, subject to the rr_ptr order.
- Requests are sampled every cycle; a request dropped before grant is simply not granted. No state is kept per requester.
- Simultaneous all-request: granting rotates 0,1,...,N_REQ-1,0 when starting from reset.
- Reset mid-operation: a pending broadcast is dropped (cdb_valid_o=0 the cycle after reset); the producer was already accepted and has retired.
- Errors: out-of-range parameter combinations are rejected at elaboration with a generate-time error.

Optional Feature:
- Macro: CDB_ARB_BYPASS_EN.
- Defined:
  - cdb_valid_o, cdb_tag_o and cdb_data_o are combinational from the current-cycle winner, so request to broadcast takes 0 cycles.
  - The output registers are removed; rr_ptr behaviour is unchanged.
  - All outputs are 0 while rst_n=0 or when there is no grant.
- Undefined: registered outputs as described above.

Test Plan (N_REQ=4, DATA_WIDTH=4, TAG_BASE=1, cdb_enable_i=1 unless stated):
- Reset, then single request: req_i=0010, data1=0x7 -> accepted_o=0010 the same cycle; next cycle cdb_valid_o=1, tag=2, data=0x7; rr_ptr=2.
- Reset, then all four requesting continuously with data=i+3 -> grant order 0,1,2,3,0; CDB tags 1,2,3,4,1 with data 3,4,5,6,3 on consecutive cycles, no idle cycle.
- rr_ptr=3 (after a grant to 2), req_i=1001 -> grant 3 (tag 4); next cycle grant 0 (tag 1). This checks wrap-around.
- cdb_enable_i=0 with req_i=1111 for 3 cycles -> accepted_o=0000 and cdb_valid_o=0 throughout, rr_ptr unchanged; re-enable -> grant resumes at the old rr_ptr.
- Assert rst_n=0 in the cycle after a grant to 1 -> accepted_o=0 during reset, cdb_valid_o=0 after the edge, rr_ptr=0; after release with req_i=1111, first grant is 0.
- With CDB_ARB_BYPASS_EN defined, req_i=0100, data2=0xA -> in the same cycle cdb_valid_o=1, tag=3, data=0xA, accepted_o=0100.
